write_back_stage: RTL
=====================

// Module: write_back_stage
// PURPOSE
//   Final stage of the RV64 ready/valid pipeline. Accepts one retired-instruction bundle
//   from the memory stage, selects and load-extends the result, and drives the register
//   file write port exactly once per instruction on commit. Commit is back-pressured by a
//   commit sink (difftest/trace), and the block maintains the 64-bit instret counter.
// PARAMETERS
//   XLEN        64   datapath width; only 64 is supported
//   RESET_PC    64'h8000_0000   value of commit_o_pc while empty/after reset
// PORTS
//   clk                    in   1    clock
//   rst                    in   1    synchronous, active-high reset
//   mem_i_valid            in   1    memory stage bundle valid
//   mem_o_ready            out  1    this stage can accept a bundle
//   mem_i_pc               in   64   instruction PC
//   mem_i_inst             in   32   instruction word
//   mem_i_rd               in   5    destination register
//   mem_i_reg_wen          in   1    instruction writes rd
//   mem_i_wb_sel           in   2    0=ALU, 1=LOAD, 2=PC+4, 3=CSR
//   mem_i_alu_result       in   64   ALU result
//   mem_i_load_raw         in   64   load data, already shifted so byte 0 is bit[7:0]
//   mem_i_load_funct3      in   3    load funct3 (LB/LH/LW/LD/LBU/LHU/LWU)
//   mem_i_csr_rdata        in   64   CSR old value
//   write_back_o_rd        out  5    regfile write index
//   write_back_o_data      out  64   regfile write data
//   write_back_o_reg_wen   out  1    regfile write enable (one-cycle pulse per commit)
//   commit_o_valid         out  1    a held instruction is ready to commit
//   commit_i_ready         in   1    commit sink accepts
//   commit_o_pc            out  64   PC of held instruction
//   commit_o_inst          out  32   instruction word of held instruction
//   commit_o_instret       out  64   count of committed instructions
// BEHAVIOUR
//   - One-entry stage register (valid_q + bundle). accept = mem_i_valid & mem_o_ready;
//     commit = commit_o_valid & commit_i_ready.
//   - mem_o_ready = !valid_q | commit_i_ready (full-throughput; same-cycle commit+accept
//     replaces the entry, valid_q stays 1). No combinational path mem_i_valid -> mem_o_ready.
//   - Result computed from inputs at accept and registered (data_q); outputs never depend
//     combinationally on mem_i_*. Latency accept -> commit_o_valid: 1 cycle.
//   - Result select: ALU -> alu_result; PC+4 -> pc+4 mod 2^64; CSR -> csr_rdata;
//     LOAD by funct3: 000 sext8, 001 sext16, 010 sext32, 011 raw, 100 zext8, 101 zext16,
//     110 zext32, 111 -> 64'd0 (illegal, no trap raised here).
//   - commit_o_valid = valid_q. commit_o_pc/inst hold the entry; while empty pc=RESET_PC,
//     inst=32'h0000_0013 (NOP). Held values stable while commit_o_valid & !commit_i_ready.
//   - write_back_o_reg_wen = commit & reg_wen_q & (rd_q != 0). Asserted only in the commit
//     cycle, so a stalled instruction writes the regfile exactly once. rd/data outputs are
//     rd_q/data_q (0 when empty).
//   - instret: +1 on each commit cycle; wraps at 2^64-1 -> 0.
//   - Reset: valid_q=0, rd_q=0, data_q=0, reg_wen_q=0, instret=0; all outputs 0 except
//     commit_o_pc=RESET_PC, commit_o_inst=NOP, mem_o_ready=1 in the first cycle after reset.
//     Reset mid-stall drops the held instruction without writing the regfile or counting.
//   - Reset has priority over accept and commit in the same cycle.
// TESTING
//   1. ALU op rd=5, data=64'h1234, commit_i_ready=1 -> next cycle wen=1, rd=5, data=64'h1234,
//      instret 0->1.
//   2. LOAD funct3=000 raw=64'h80, then 100 raw=64'h80 -> data 64'hFFFF_FFFF_FFFF_FF80, then
//      64'h80; funct3=010 raw=64'h8000_0000 -> 64'hFFFF_FFFF_8000_0000; 111 -> 0.
//   3. commit_i_ready=0 for 3 cycles with entry held -> wen=0, mem_o_ready=0, pc/inst stable;
//      ready=1 -> single wen pulse, instret +1 only.
//   4. Back-to-back valid stream of 8 instrs, ready=1 -> 8 commits in 8 consecutive cycles,
//      instret=8; rd=0 instr commits with wen=0 but still counts.
//   5. JAL pc=64'hFFFF_FFFF_FFFF_FFFC wb_sel=2 -> data 64'h0; force instret=2^64-1 via
//      preload path in bench -> wraps to 0.
//   6. rst asserted while entry stalled -> next cycle valid=0, wen=0, instret=0, mem_o_ready=1.

Source files
------------

// File: rtl/write_back_stage.sv
// Final pipeline stage: registers the retiring bundle, drives the
// regfile write port once per commit and keeps the instret counter.
module write_back_stage #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_i_valid,
  output logic            mem_o_ready,
  input  logic [63:0]     mem_i_pc,
  input  logic [31:0]     mem_i_inst,
  input  logic [4:0]      mem_i_rd,
  input  logic            mem_i_reg_wen,
  input  logic [1:0]      mem_i_wb_sel,
  input  logic [XLEN-1:0] mem_i_alu_result,
  input  logic [XLEN-1:0] mem_i_load_raw,
  input  logic [2:0]      mem_i_load_funct3,
  input  logic [XLEN-1:0] mem_i_csr_rdata,
  output logic [4:0]      write_back_o_rd,
  output logic [XLEN-1:0] write_back_o_data,
  output logic            write_back_o_reg_wen,
  output logic            commit_o_valid,
  input  logic            commit_i_ready,
  output logic [63:0]     commit_o_pc,
  output logic [31:0]     commit_o_inst,
  output logic [63:0]     commit_o_instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [63:0]     pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic            reg_wen;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  logic            valid_q;
  wb_entry_t       entry_q;
  logic [63:0]     instret_q;
  logic            accept;
  logic            commit;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] result;

  assign commit = valid_q & commit_i_ready;
  assign mem_o_ready = ~valid_q | commit_i_ready;
  assign accept = mem_i_valid & mem_o_ready;

  always_comb begin
    load_val = '0;
    unique case (mem_i_load_funct3)
      3'b000: load_val = {{56{mem_i_load_raw[7]}}, mem_i_load_raw[7:0]};
      3'b001: load_val = {{48{mem_i_load_raw[15]}}, mem_i_load_raw[15:0]};
      3'b010: load_val = {{32{mem_i_load_raw[31]}}, mem_i_load_raw[31:0]};
      3'b011: load_val = mem_i_load_raw;
      3'b100: load_val = {56'd0, mem_i_load_raw[7:0]};
      3'b101: load_val = {48'd0, mem_i_load_raw[15:0]};
      3'b110: load_val = {32'd0, mem_i_load_raw[31:0]};
      3'b111: load_val = '0;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (mem_i_wb_sel)
      2'd0: result = mem_i_alu_result;
      2'd1: result = load_val;
      2'd2: result = mem_i_pc + 64'd4;
      2'd3: result = mem_i_csr_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      entry_q   <= '0;
      instret_q <= '0;
    end else begin
      if (accept) begin
        valid_q         <= 1'b1;
        entry_q.pc      <= mem_i_pc;
        entry_q.inst    <= mem_i_inst;
        entry_q.rd      <= mem_i_rd;
        entry_q.reg_wen <= mem_i_reg_wen;
        entry_q.data    <= result;
      end else if (commit) begin
        valid_q <= 1'b0;
      end
      if (commit)
        instret_q <= instret_q + 64'd1;
    end
  end

  // Outputs read as a clean idle bundle whenever the stage is empty.
  assign commit_o_valid       = valid_q;
  assign commit_o_pc          = valid_q ? entry_q.pc : RESET_PC;
  assign commit_o_inst        = valid_q ? entry_q.inst : NOP;
  assign commit_o_instret     = instret_q;
  assign write_back_o_rd      = valid_q ? entry_q.rd : 5'd0;
  assign write_back_o_data    = valid_q ? entry_q.data : '0;
  assign write_back_o_reg_wen = commit & entry_q.reg_wen &
                                (entry_q.rd != 5'd0);

endmodule
